// File: rtl/jacobi_pivot_search.sv
// -----------------------------------------------------------------------------
// jacobi_pivot_search
//
// Purpose:
//   Scans a row-major stream of a 32x32 single-precision matrix and finds the
//   strictly-upper-triangular element with the largest magnitude (the Jacobi
//   rotation pivot). The magnitude compare is an unsigned compare of the
//   IEEE-754 bits [30:0]. This works because, for non-NaN values, that bit
//   pattern is monotonic in |x|. NaN candidates are skipped. +/-Inf is a
//   legal candidate. On a tie, the earliest element in stream order wins.
//
// Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous active-high reset
//   in_valid   in   1   element valid
//   in_ready   out  1   block accepts element (high while scanning)
//   in_data    in   32  IEEE-754 single, element k -> row k[9:5], col k[4:0]
//   out_valid  out  1   pivot result valid (held until out_ready)
//   out_ready  in   1   consumer accepts result
//   out_i      out  5   pivot row index
//   out_j      out  5   pivot column index (always > out_i)
//   out_val    out  32  pivot element exactly as received (sign kept)
//   out_zero   out  1   no off-diagonal upper element had |x| > 0
//
// Optional feature (macro JACOBI_PIVOT_THRESH_EN):
//   thresh     in   31  convergence threshold (magnitude bits)
//   out_conv   out  1   final best magnitude < thresh
// -----------------------------------------------------------------------------
module jacobi_pivot_search (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
`ifdef JACOBI_PIVOT_THRESH_EN
   input  logic [30:0] thresh,
   output logic        out_conv,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_i,
   output logic [4:0]  out_j,
   output logic [31:0] out_val,
   output logic        out_zero
);

   typedef enum logic {
      SCAN = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [9:0]  LAST_IDX  = 10'd1023;
   localparam logic [4:0]  INIT_I    = 5'd0;
   localparam logic [4:0]  INIT_J    = 5'd1;
   localparam logic [30:0] INIT_MAG  = 31'd0;
   localparam logic [31:0] INIT_VAL  = 32'h0000_0000;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;

   // Running best of the scan in progress.
   logic [30:0] best_mag_q, best_mag_d;
   logic [4:0]  best_i_q, best_i_d;
   logic [4:0]  best_j_q, best_j_d;
   logic [31:0] best_val_q, best_val_d;

   // Published result. It is kept apart from the running best so that the
   // outputs stay frozen across HOLD while the best is re-initialised.
   logic [4:0]  res_i_q, res_i_d;
   logic [4:0]  res_j_q, res_j_d;
   logic [31:0] res_val_q, res_val_d;
   logic        res_zero_q, res_zero_d;
`ifdef JACOBI_PIVOT_THRESH_EN
   logic        res_conv_q, res_conv_d;
`endif

   // Element classification
   logic [4:0]  row;
   logic [4:0]  col;
   logic        accept;
   logic        is_nan;
   logic        is_cand;
   logic        take;
   logic        last;

   // Best including the element currently being accepted.
   logic [30:0] upd_mag;
   logic [4:0]  upd_i;
   logic [4:0]  upd_j;
   logic [31:0] upd_val;

   assign row     = cnt_q[9:5];
   assign col     = cnt_q[4:0];
   assign accept  = in_valid && (state_q == SCAN);
   assign is_nan  = (&in_data[30:23]) && (|in_data[22:0]);
   assign is_cand = (col > row) && !is_nan;
   // A strict compare keeps the earliest element on ties.
   // It also means a -0.0 candidate can never displace the initial zero best.
   assign take    = accept && is_cand && (in_data[30:0] > best_mag_q);
   assign last    = accept && (cnt_q == LAST_IDX);

   assign upd_mag = take ? in_data[30:0] : best_mag_q;
   assign upd_i   = take ? row           : best_i_q;
   assign upd_j   = take ? col           : best_j_q;
   assign upd_val = take ? in_data       : best_val_q;

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      best_mag_d = best_mag_q;
      best_i_d   = best_i_q;
      best_j_d   = best_j_q;
      best_val_d = best_val_q;
      res_i_d    = res_i_q;
      res_j_d    = res_j_q;
      res_val_d  = res_val_q;
      res_zero_d = res_zero_q;
`ifdef JACOBI_PIVOT_THRESH_EN
      res_conv_d = res_conv_q;
`endif
      in_ready   = 1'b0;
      out_valid  = 1'b0;

      case (state_q)
         SCAN: begin
            in_ready = 1'b1;
            if (accept) begin
               cnt_d      = cnt_q + 10'd1;
               best_mag_d = upd_mag;
               best_i_d   = upd_i;
               best_j_d   = upd_j;
               best_val_d = upd_val;
               if (last) begin
                  state_d    = HOLD;
                  res_i_d    = upd_i;
                  res_j_d    = upd_j;
                  res_val_d  = upd_val;
                  res_zero_d = (upd_mag == INIT_MAG);
`ifdef JACOBI_PIVOT_THRESH_EN
                  res_conv_d = (upd_mag < thresh);
`endif
                  // Arm the running best for the next matrix now.
                  // The HOLD->SCAN transition then needs no extra work.
                  best_mag_d = INIT_MAG;
                  best_i_d   = INIT_I;
                  best_j_d   = INIT_J;
                  best_val_d = INIT_VAL;
               end
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = SCAN;
               cnt_d   = 10'd0;
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SCAN;
         cnt_q      <= 10'd0;
         best_mag_q <= INIT_MAG;
         best_i_q   <= INIT_I;
         best_j_q   <= INIT_J;
         best_val_q <= INIT_VAL;
         res_i_q    <= INIT_I;
         res_j_q    <= INIT_J;
         res_val_q  <= INIT_VAL;
         res_zero_q <= 1'b1;
`ifdef JACOBI_PIVOT_THRESH_EN
         res_conv_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         best_mag_q <= best_mag_d;
         best_i_q   <= best_i_d;
         best_j_q   <= best_j_d;
         best_val_q <= best_val_d;
         res_i_q    <= res_i_d;
         res_j_q    <= res_j_d;
         res_val_q  <= res_val_d;
         res_zero_q <= res_zero_d;
`ifdef JACOBI_PIVOT_THRESH_EN
         res_conv_q <= res_conv_d;
`endif
      end
   end

   assign out_i    = res_i_q;
   assign out_j    = res_j_q;
   assign out_val  = res_val_q;
   assign out_zero = res_zero_q;
`ifdef JACOBI_PIVOT_THRESH_EN
   assign out_conv = res_conv_q;
`endif

endmodule

// File: tb/tb_jacobi_pivot_search.sv
module tb_jacobi_pivot_search;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_i;
   logic [4:0]  out_j;
   logic [31:0] out_val;
   logic        out_zero;
`ifdef JACOBI_PIVOT_THRESH_EN
   logic [30:0] thresh;
   logic        out_conv;
`endif

   always #5 clk = ~clk;

   jacobi_pivot_search dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef JACOBI_PIVOT_THRESH_EN
      .thresh    (thresh),
      .out_conv  (out_conv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_i     (out_i),
      .out_j     (out_j),
      .out_val   (out_val),
      .out_zero  (out_zero)
   );

   typedef struct packed {
      logic [4:0]  i;
      logic [4:0]  j;
      logic [31:0] val;
      logic        zero;
      logic        conv;
   } res_t;

   res_t        exp_q[$];
   logic [31:0] mat [1024];
   int          n_cmp = 0;
   int          n_err = 0;
   int          hold_req = 0;
   int          n_mat = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: walk the strict upper triangle in stream order.
   // Keep the first element of the largest |x|, and skip NaNs.
   function automatic res_t model();
      res_t        r;
      logic [31:0] x;
      logic [30:0] best;
      best   = 31'd0;
      r.i    = 5'd0;
      r.j    = 5'd1;
      r.val  = 32'd0;
      for (int ri = 0; ri < 32; ri++) begin
         for (int ci = ri + 1; ci < 32; ci++) begin
            x = mat[ri*32 + ci];
            if (!(x[30:23] == 8'hFF && x[22:0] != 23'd0) && x[30:0] > best) begin
               best  = x[30:0];
               r.i   = 5'(ri);
               r.j   = 5'(ci);
               r.val = x;
            end
         end
      end
      r.zero = (best == 31'd0);
`ifdef JACOBI_PIVOT_THRESH_EN
      r.conv = (best < thresh);
`else
      r.conv = 1'b1;
`endif
      return r;
   endfunction

   task automatic fill_zero();
      for (int k = 0; k < 1024; k++) mat[k] = 32'h0;
   endtask

   task automatic fill_rand();
      logic [31:0] v;
      for (int k = 0; k < 1024; k++) begin
         v = $urandom;
         if ($urandom_range(0, 15) == 0) v[30:23] = 8'hFF;   // NaN / Inf
         else if ($urandom_range(0, 3) == 0) v[30:28] = 3'b000; // small values
         mat[k] = v;
      end
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      chk({tag, " in_ready"},  32'(in_ready),  32'd1);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, " out_i"},     32'(out_i),     32'd0);
      chk({tag, " out_j"},     32'(out_j),     32'd1);
      chk({tag, " out_val"},   out_val,        32'd0);
      chk({tag, " out_zero"},  32'(out_zero),  32'd1);
`ifdef JACOBI_PIVOT_THRESH_EN
      chk({tag, " out_conv"},  32'(out_conv),  32'd1);
`endif
   endtask

   // Sends elements 0..stop_at-1 of mat, with random in_valid gaps.
   // A full matrix also queues its expected result.
   task automatic send_matrix(input int stop_at);
      int k;
      int waitc;
      k = 0;
      while (k < stop_at) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk); #1;
         end else begin
            in_valid = 1'b1;
            in_data  = mat[k];
            waitc    = 0;
            while (!in_ready) begin
               @(posedge clk); #1;
               waitc++;
               if (waitc > 500) begin
                  $display("FAIL in_ready timeout: got 0 expected 1 (element %0d)", k);
                  $fatal(1, "in_ready stuck low");
               end
            end
            @(posedge clk); #1;
            k++;
         end
      end
      in_valid = 1'b0;
      in_data  = 32'h0;
      if (stop_at == 1024) begin
         exp_q.push_back(model());
         n_mat++;
         @(negedge clk);
         chk($sformatf("latency out_valid m%0d", n_mat), 32'(out_valid), 32'd1);
      end
   endtask

   // Consumer: random out_ready.
   // hold_req forces it low for that many valid cycles.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hold_req > 0) begin
            out_ready = 1'b0;
            if (out_valid) hold_req--;
         end else begin
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: every valid cycle is checked against the head of the queue.
   // This also covers stability while out_ready is low.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected result: got out_valid=1 expected none pending");
            end else begin
               e = exp_q[0];
               chk("out_i",    32'(out_i),    32'(e.i));
               chk("out_j",    32'(out_j),    32'(e.j));
               chk("out_val",  out_val,       e.val);
               chk("out_zero", 32'(out_zero), 32'(e.zero));
`ifdef JACOBI_PIVOT_THRESH_EN
               chk("out_conv", 32'(out_conv), 32'(e.conv));
`endif
               chk("in_ready in HOLD", 32'(in_ready), 32'd0);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int drain;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 32'h0;
`ifdef JACOBI_PIVOT_THRESH_EN
      thresh   = 31'h3A83_126F;
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_state("reset");

      // Identity matrix
      fill_zero();
      for (int r = 0; r < 32; r++) mat[r*33] = 32'h3F80_0000;
      send_matrix(1024);

      // Single upper pivot; the larger lower-triangle mirror is ignored
      fill_zero();
      mat[3*32+17] = 32'hC080_0000;
      mat[17*32+3] = 32'h4100_0000;
      send_matrix(1024);

      // Tie keeps the earliest element; the diagonal 100.0 is ignored
      fill_zero();
      mat[2*32+5]  = 32'h4000_0000;
      mat[4*32+9]  = 32'hC000_0000;
      mat[1*32+1]  = 32'h42C8_0000;
      send_matrix(1024);

      // NaN is skipped
      fill_zero();
      mat[31]      = 32'h7FC0_0000;
      mat[30*32+31] = 32'h3FC0_0000;
      send_matrix(1024);

      // All -0.0 counts as zero
      for (int k = 0; k < 1024; k++) mat[k] = 32'h8000_0000;
      send_matrix(1024);

      // -Inf wins over finite values, and a large-payload NaN is ignored
      fill_rand();
      mat[5*32+6]  = 32'hFF80_0000;
      mat[7*32+8]  = 32'h7FFF_FFFF;
      send_matrix(1024);

      // Consumer stalls 20 cycles, then a back-to-back second matrix
      hold_req = 20;
      fill_rand();
      send_matrix(1024);
      fill_rand();
      send_matrix(1024);

      // Reset at element 500 discards the partial scan
      fill_rand();
      mat[0*32+1] = 32'h7F7F_FFFF;   // would dominate if the partial scan leaked
      send_matrix(500);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check_reset_state("mid-scan reset");
      fill_rand();
      send_matrix(1024);

`ifdef JACOBI_PIVOT_THRESH_EN
      // Convergence threshold 1e-3
      fill_zero();
      mat[1*32+8] = 32'h3A03_126F;   // 5e-4
      send_matrix(1024);
      fill_zero();
      mat[1*32+8] = 32'hBB03_126F;   // -2e-3
      send_matrix(1024);
`endif

      repeat (3) begin
         fill_rand();
         send_matrix(1024);
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 2000) begin
         @(posedge clk);
         drain++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d results pending expected 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
